// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory arbiter
//
// Contents:
//   owner_e             which requester's response comes back next cycle
//   STARVE_MAX_DEFAULT  default fetch starvation limit
//   STARVE_CNT_W        width of the starvation counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int STARVE_CNT_W       = 4;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - fetch, data and RAM signal bundle for the arbiter
//
// Groups:
//   fetch : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   data  : d_req, d_we, d_addr, d_wdata, d_wstrb -> d_gnt, d_rvalid, d_rdata
//   ram   : mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb <- mem_rdata
// Modports:
//   slave  : the arbiter's view
//   master : the requesters' and RAM's view
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_perf.sv
// rtl/mem_arb_perf.sv - contention and fetch-stall event counters
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   if_req, d_req    current requests
//   if_gnt           fetch grant this cycle
//   conflict_count   cycles with both requests high (wraps at 2^32)
//   if_stall_count   cycles with fetch requesting but not granted (wraps at 2^32)
module mem_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic        d_req,
  input  logic        if_gnt,
  output logic [31:0] conflict_count,
  output logic [31:0] if_stall_count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_count <= '0;
      if_stall_count <= '0;
    end else begin
      if (if_req && d_req)
        conflict_count <= conflict_count + 32'd1;
      if (if_req && !if_gnt)
        if_stall_count <= if_stall_count + 32'd1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port RAM arbiter for instruction fetch and load/store
//
// Grants at most one of fetch/data per cycle (data first, fetch forced after
// STARVE_MAX consecutive denied cycles) and routes the 1-cycle RAM response
// back to whichever requester owned the access.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   bus               unified_mem_arbiter_if.slave (fetch, data and RAM sides)
//   conflict_count    only with ARB_PERF_EN: cycles with both requests high
//   if_stall_count    only with ARB_PERF_EN: cycles fetch requested but was denied
// Optional feature macro: ARB_PERF_EN
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  unified_mem_arbiter_if.slave    bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]             conflict_count,
  output logic [31:0]             if_stall_count
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  owner_e                  owner;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  logic                    fetch_wins;
  logic                    if_gnt;
  logic                    d_gnt;
  logic [ADDR_W-1:0]       cmd_addr;
  logic [DATA_W-1:0]       cmd_wdata;
  logic [STRB_W-1:0]       cmd_wstrb;
  logic                    cmd_we;

  // Fetch takes the slot when it is alone or has been starved long enough;
  // otherwise data owns it. Reset masks both grants regardless of requests.
  always_comb begin
    fetch_wins = bus.if_req && (!bus.d_req || (starve_cnt == STARVE_LIM));
    if_gnt     = !reset && fetch_wins;
    d_gnt      = !reset && bus.d_req && !fetch_wins;

    cmd_addr   = if_gnt ? bus.if_addr : bus.d_addr;
    cmd_we     = d_gnt && bus.d_we;
    cmd_wdata  = bus.d_wdata;
    cmd_wstrb  = d_gnt ? bus.d_wstrb : '0;
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = if_gnt || d_gnt;
  assign bus.mem_we    = cmd_we;
  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;
  assign bus.mem_wstrb = cmd_wstrb;

  // The owner register is updated at the reset edge too late to cancel a
  // response already pending, so rvalid is also masked while reset is high.
  assign bus.if_rvalid = (owner == OWN_IF) && !reset;
  assign bus.d_rvalid  = (owner == OWN_D) && !reset;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= OWN_IDLE;
      starve_cnt <= '0;
    end else begin
      if (if_gnt)
        owner <= OWN_IF;
      else if (d_gnt)
        owner <= OWN_D;
      else
        owner <= OWN_IDLE;

      if (!bus.if_req || if_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef ARB_PERF_EN
  mem_arb_perf u_perf (
    .clk            (clk),
    .reset          (reset),
    .if_req         (bus.if_req),
    .d_req          (bus.d_req),
    .if_gnt         (if_gnt),
    .conflict_count (conflict_count),
    .if_stall_count (if_stall_count)
  );
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_PERF_EN
  logic [31:0] conflict_count;
  logic [31:0] if_stall_count;
`endif

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus)
`ifdef ARB_PERF_EN
    ,
    .conflict_count (conflict_count),
    .if_stall_count (if_stall_count)
`endif
  );

  // Write-first synchronous RAM, word addressed by addr[11:2].
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (reset) begin
      ram[10'h004] = 32'h0050_0093;
      ram[10'h080] = 32'h1122_3344;
    end
    if (bus.mem_en) begin
      if (bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b])
            ram[bus.mem_addr[11:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      bus.mem_rdata <= ram[bus.mem_addr[11:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h200;
    bus.d_wdata = 32'h0;
    bus.d_wstrb = 4'hF;

    // Reset: everything quiet even with both requests high.
    tick(); tick();
    chk("rst_if_gnt",    32'(bus.if_gnt),    32'd0);
    chk("rst_d_gnt",     32'(bus.d_gnt),     32'd0);
    chk("rst_mem_en",    32'(bus.mem_en),    32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_d_rvalid",  32'(bus.d_rvalid),  32'd0);

    tick();
    reset      = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    bus.d_we   = 1'b0;
    settle();
    chk("idle_mem_en", 32'(bus.mem_en), 32'd0);
    chk("idle_mem_we", 32'(bus.mem_we), 32'd0);

    // Fetch only.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    settle();
    chk("f_if_gnt",    32'(bus.if_gnt),    32'd1);
    chk("f_d_gnt",     32'(bus.d_gnt),     32'd0);
    chk("f_mem_en",    32'(bus.mem_en),    32'd1);
    chk("f_mem_we",    32'(bus.mem_we),    32'd0);
    chk("f_mem_addr",  bus.mem_addr,       32'h10);
    chk("f_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    tick();
    bus.if_req = 1'b0;
    settle();
    chk("f_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("f_if_rdata",  bus.if_rdata,       32'h0050_0093);
    chk("f_d_rvalid",  32'(bus.d_rvalid),  32'd0);

    // Contest: data first, fetch follows once data drops.
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h200;
    settle();
    chk("c_d_gnt",    32'(bus.d_gnt),  32'd1);
    chk("c_if_gnt",   32'(bus.if_gnt), 32'd0);
    chk("c_mem_addr", bus.mem_addr,    32'h200);
    tick();
    bus.d_req = 1'b0;
    settle();
    chk("c_d_rvalid",  32'(bus.d_rvalid),  32'd1);
    chk("c_d_rdata",   bus.d_rdata,        32'h1122_3344);
    chk("c_if_gnt2",   32'(bus.if_gnt),    32'd1);
    chk("c_mem_addr2", bus.mem_addr,       32'h10);
    tick();
    bus.if_req = 1'b0;
    settle();
    chk("c_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("c_if_rdata",  bus.if_rdata,       32'h0050_0093);
    chk("c_d_rvalid2", 32'(bus.d_rvalid),  32'd0);

    // Starvation: fetch forced through every fifth cycle.
    tick();
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk($sformatf("s_if_gnt_%0d", c),    32'(bus.if_gnt),    32'(c == 4 || c == 9));
      chk($sformatf("s_d_gnt_%0d", c),     32'(bus.d_gnt),     32'(c != 4 && c != 9));
      chk($sformatf("s_if_rvalid_%0d", c), 32'(bus.if_rvalid), 32'(c == 5));
      chk($sformatf("s_d_rvalid_%0d", c),  32'(bus.d_rvalid),  32'(c >= 1 && c != 5));
      tick();
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    settle();
    chk("s_if_rvalid_end", 32'(bus.if_rvalid), 32'd1);

    // Write then fetch of the same word, then a partial-strobe write.
    tick();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h40;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_wstrb = 4'hF;
    settle();
    chk("w_d_gnt",     32'(bus.d_gnt),     32'd1);
    chk("w_mem_we",    32'(bus.mem_we),    32'd1);
    chk("w_mem_wstrb", 32'(bus.mem_wstrb), 32'hF);
    chk("w_mem_wdata", bus.mem_wdata,      32'hDEAD_BEEF);
    tick();
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    settle();
    chk("w_d_ack",  32'(bus.d_rvalid), 32'd1);
    chk("w_if_gnt", 32'(bus.if_gnt),   32'd1);
    tick();
    bus.if_req = 1'b0;
    settle();
    chk("w_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("w_if_rdata",  bus.if_rdata,       32'hDEAD_BEEF);

    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_wdata = 32'h0000_CAFE;
    bus.d_wstrb = 4'h3;
    settle();
    chk("p_mem_wstrb", 32'(bus.mem_wstrb), 32'h3);
    tick();
    bus.d_we = 1'b0;
    settle();
    chk("p_d_gnt_rd", 32'(bus.d_gnt), 32'd1);
    tick();
    bus.d_req = 1'b0;
    settle();
    chk("p_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("p_d_rdata",  bus.d_rdata,       32'hDEAD_CAFE);

    // Reset arriving while a data response is pending.
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h200;
    settle();
    chk("r_d_gnt", 32'(bus.d_gnt), 32'd1);
    tick();
    reset      = 1'b1;
    bus.if_req = 1'b1;
    settle();
    chk("r_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("r_if_gnt",   32'(bus.if_gnt),   32'd0);
    chk("r_d_gnt2",   32'(bus.d_gnt),    32'd0);
    chk("r_mem_en",   32'(bus.mem_en),   32'd0);
    tick();
    chk("r_d_rvalid2", 32'(bus.d_rvalid), 32'd0);
    tick();
    reset      = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    settle();
    chk("r_post_d_rvalid",  32'(bus.d_rvalid),  32'd0);
    chk("r_post_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    settle();
    chk("r_post_d_gnt",  32'(bus.d_gnt),  32'd1);
    chk("r_post_if_gnt", 32'(bus.if_gnt), 32'd0);

`ifdef ARB_PERF_EN
    // Three contested cycles then two fetch-only cycles from a fresh reset.
    tick();
    reset      = 1'b1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
    chk("perf_rst_conf",  conflict_count, 32'd0);
    chk("perf_rst_stall", if_stall_count, 32'd0);
    reset      = 1'b0;
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    tick(); tick(); tick();
    bus.d_req = 1'b0;
    tick(); tick();
    bus.if_req = 1'b0;
    settle();
    chk("perf_conflict", conflict_count, 32'd3);
    chk("perf_stall",    if_stall_count, 32'd3);
`endif

    tick();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
